// File: rtl/bzled_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bzled_seq_ctrl
// Brief    : Register file plus breathing-ramp and beep-pattern sequencers
//            producing the five setting words of the buzzer/RGB-LED PWM block.
// Revision : 1.0 - initial release
// ============================================================================
module bzled_seq_ctrl #(
    parameter int TICK_DIV = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_EN,
    input  logic [2:0]  WR_ADDR,
    input  logic [31:0] WR_DATA,
    output logic [31:0] LED_FREQ_Set,
    output logic [31:0] BZ_FREQ_Set,
    output logic [31:0] LEDR_Puty_Set,
    output logic [31:0] LEDG_Puty_Set,
    output logic [31:0] LEDB_Puty_Set,
    output logic        BUSY
);

    localparam int                   c_PRESC_W   = $clog2(TICK_DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    logic [31:0]          r_led_freq;
    logic [31:0]          r_bz_freq;
    logic [31:0]          r_duty_r;
    logic [31:0]          r_duty_g;
    logic [31:0]          r_duty_b;
    logic [4:0]           r_mode;
    logic [31:0]          r_step;
    logic [c_PRESC_W-1:0] r_presc;
    logic [31:0]          r_ramp;
    logic                 r_dir_up;
    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [11:0]          r_on_len;
    logic [11:0]          r_off_len;
    logic [11:0]          r_phase;

    logic [7:0]  w_wr;
    logic        w_tick;
    logic        w_beep_wr;
    logic [31:0] w_bz_freq_nxt;
    logic [31:0] w_duty_r_nxt;
    logic [31:0] w_duty_g_nxt;
    logic [31:0] w_duty_b_nxt;
    logic [4:0]  w_mode_nxt;
    logic [32:0] w_sum;
    logic [31:0] w_ramp_nxt;
    logic        w_dir_up_nxt;
    logic [31:0] w_idle_bz;
    logic [11:0] w_on_req;
    logic [11:0] w_off_req;

    assign w_wr          = WR_EN ? (8'd1 << WR_ADDR) : 8'd0;
    assign w_tick        = (r_presc == c_PRESC_MAX);
    assign w_beep_wr     = w_wr[7];
    assign w_bz_freq_nxt = w_wr[1] ? WR_DATA : r_bz_freq;
    assign w_duty_r_nxt  = w_wr[2] ? WR_DATA : r_duty_r;
    assign w_duty_g_nxt  = w_wr[3] ? WR_DATA : r_duty_g;
    assign w_duty_b_nxt  = w_wr[4] ? WR_DATA : r_duty_b;
    assign w_mode_nxt    = w_wr[5] ? WR_DATA[4:0] : r_mode;
    assign w_sum         = {1'b0, r_ramp} + {1'b0, r_step};
    assign w_idle_bz     = w_mode_nxt[4] ? w_bz_freq_nxt : 32'd0;
    assign w_on_req      = (WR_DATA[19:8] == 12'd0) ? 12'd1 : WR_DATA[19:8];
    assign w_off_req     = (WR_DATA[31:20] == 12'd0) ? 12'd1 : WR_DATA[31:20];
    assign LED_FREQ_Set  = r_led_freq;

    // The up-compare uses a 33-bit sum so a huge STEP clamps instead of wrapping.
    always_comb begin
        w_ramp_nxt   = r_ramp;
        w_dir_up_nxt = r_dir_up;
        if (!w_mode_nxt[0]) begin
            w_ramp_nxt   = 32'd0;
            w_dir_up_nxt = 1'b1;
        end else if (w_tick && (r_step != 32'd0)) begin
            if (r_dir_up) begin
                if (w_sum >= {1'b0, r_led_freq}) begin
                    w_ramp_nxt   = r_led_freq;
                    w_dir_up_nxt = 1'b0;
                end else begin
                    w_ramp_nxt = w_sum[31:0];
                end
            end else begin
                if (r_ramp <= r_step) begin
                    w_ramp_nxt   = 32'd0;
                    w_dir_up_nxt = 1'b1;
                end else begin
                    w_ramp_nxt = r_ramp - r_step;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_led_freq    <= 32'd0;
            r_bz_freq     <= 32'd0;
            r_duty_r      <= 32'd0;
            r_duty_g      <= 32'd0;
            r_duty_b      <= 32'd0;
            r_mode        <= 5'd0;
            r_step        <= 32'd0;
            r_presc       <= '0;
            r_ramp        <= 32'd0;
            r_dir_up      <= 1'b1;
            LEDR_Puty_Set <= 32'd0;
            LEDG_Puty_Set <= 32'd0;
            LEDB_Puty_Set <= 32'd0;
        end else begin
            if (w_wr[0]) r_led_freq <= WR_DATA;
            if (w_wr[6]) r_step     <= WR_DATA;
            r_bz_freq <= w_bz_freq_nxt;
            r_duty_r  <= w_duty_r_nxt;
            r_duty_g  <= w_duty_g_nxt;
            r_duty_b  <= w_duty_b_nxt;
            r_mode    <= w_mode_nxt;
            r_ramp    <= w_ramp_nxt;
            r_dir_up  <= w_dir_up_nxt;
            if (w_beep_wr || w_tick) r_presc <= '0;
            else                     r_presc <= r_presc + 1'b1;
            LEDR_Puty_Set <= (w_mode_nxt[0] && w_mode_nxt[1]) ? w_ramp_nxt : w_duty_r_nxt;
            LEDG_Puty_Set <= (w_mode_nxt[0] && w_mode_nxt[2]) ? w_ramp_nxt : w_duty_g_nxt;
            LEDB_Puty_Set <= (w_mode_nxt[0] && w_mode_nxt[3]) ? w_ramp_nxt : w_duty_b_nxt;
        end
    end

    // Outputs are assigned for the state being entered, so they change with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_on_len    <= 12'd1;
            r_off_len   <= 12'd1;
            r_phase     <= 12'd0;
            BZ_FREQ_Set <= 32'd0;
            BUSY        <= 1'b0;
        end else if (w_beep_wr) begin
            if (WR_DATA[7:0] != 8'd0) begin
                r_state     <= S_ON;
                r_cnt       <= WR_DATA[7:0];
                r_on_len    <= w_on_req;
                r_off_len   <= w_off_req;
                r_phase     <= 12'd0;
                BZ_FREQ_Set <= w_bz_freq_nxt;
                BUSY        <= 1'b1;
            end else begin
                r_state     <= S_IDLE;
                BZ_FREQ_Set <= w_idle_bz;
                BUSY        <= 1'b0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    BZ_FREQ_Set <= w_idle_bz;
                    BUSY        <= 1'b0;
                end
                S_ON: begin
                    BZ_FREQ_Set <= w_bz_freq_nxt;
                    BUSY        <= 1'b1;
                    if (w_tick) begin
                        if (r_phase == r_on_len - 12'd1) begin
                            r_state     <= S_OFF;
                            r_phase     <= 12'd0;
                            BZ_FREQ_Set <= 32'd0;
                        end else begin
                            r_phase <= r_phase + 12'd1;
                        end
                    end
                end
                S_OFF: begin
                    BZ_FREQ_Set <= 32'd0;
                    BUSY        <= 1'b1;
                    if (w_tick) begin
                        if (r_phase == r_off_len - 12'd1) begin
                            r_phase <= 12'd0;
                            r_cnt   <= r_cnt - 8'd1;
                            if (r_cnt == 8'd1) begin
                                r_state     <= S_IDLE;
                                BZ_FREQ_Set <= w_idle_bz;
                                BUSY        <= 1'b0;
                            end else begin
                                r_state     <= S_ON;
                                BZ_FREQ_Set <= w_bz_freq_nxt;
                            end
                        end else begin
                            r_phase <= r_phase + 12'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    BZ_FREQ_Set <= w_idle_bz;
                    BUSY        <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bzled_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bzled_seq_ctrl
// Brief    : Directed stimulus for bzled_seq_ctrl with a per-cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bzled_seq_ctrl;

    localparam int TD = 4;

    logic        CLK     = 1'b0;
    logic        RST     = 1'b1;
    logic        WR_EN   = 1'b0;
    logic [2:0]  WR_ADDR = 3'd0;
    logic [31:0] WR_DATA = 32'd0;
    logic [31:0] LED_FREQ_Set;
    logic [31:0] BZ_FREQ_Set;
    logic [31:0] LEDR_Puty_Set;
    logic [31:0] LEDG_Puty_Set;
    logic [31:0] LEDB_Puty_Set;
    logic        BUSY;

    int n_checks = 0;
    int n_errors = 0;

    bzled_seq_ctrl #(.TICK_DIV(TD)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .WR_EN         (WR_EN),
        .WR_ADDR       (WR_ADDR),
        .WR_DATA       (WR_DATA),
        .LED_FREQ_Set  (LED_FREQ_Set),
        .BZ_FREQ_Set   (BZ_FREQ_Set),
        .LEDR_Puty_Set (LEDR_Puty_Set),
        .LEDG_Puty_Set (LEDG_Puty_Set),
        .LEDB_Puty_Set (LEDB_Puty_Set),
        .BUSY          (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: register file, tick schedule, triangle ramp and a
    // beep timeline computed from the write cycle by plain arithmetic.
    logic [31:0] m_reg [0:6];
    int          m_presc;
    longint      m_ramp;
    bit          m_up;
    longint      m_cyc = 0;
    longint      m_bw;
    longint      m_bcnt = 0;
    longint      m_bon, m_boff;
    bit          m_valid = 0;
    logic [31:0] e_led, e_bz, e_r, e_g, e_b;
    logic        e_busy;

    always @(negedge CLK) begin : p_model
        bit          tick;
        logic [31:0] mode_n;
        longint      j, per, stp;
        bit          busy, on;
        if (m_valid) begin
            check("led_freq", LED_FREQ_Set, e_led);
            check("bz_freq", BZ_FREQ_Set, e_bz);
            check("duty_r", LEDR_Puty_Set, e_r);
            check("duty_g", LEDG_Puty_Set, e_g);
            check("duty_b", LEDB_Puty_Set, e_b);
            check("busy", BUSY, e_busy);
        end
        if (RST) begin
            for (int k = 0; k < 7; k++) m_reg[k] = 32'd0;
            m_presc = 0;
            m_ramp  = 0;
            m_up    = 1;
            m_bcnt  = 0;
        end else begin
            tick   = (m_presc == TD - 1);
            mode_n = (WR_EN && WR_ADDR == 3'd5) ? WR_DATA : m_reg[5];
            stp    = longint'(m_reg[6]);
            if (!mode_n[0]) begin
                m_ramp = 0;
                m_up   = 1;
            end else if (tick && stp != 0) begin
                if (m_up) begin
                    if (m_ramp + stp >= longint'(m_reg[0])) begin
                        m_ramp = longint'(m_reg[0]);
                        m_up   = 0;
                    end else m_ramp = m_ramp + stp;
                end else begin
                    if (m_ramp <= stp) begin
                        m_ramp = 0;
                        m_up   = 1;
                    end else m_ramp = m_ramp - stp;
                end
            end
            if (WR_EN && WR_ADDR == 3'd7) m_presc = 0;
            else m_presc = tick ? 0 : m_presc + 1;
            if (WR_EN) begin
                if (WR_ADDR != 3'd7) m_reg[WR_ADDR] = WR_DATA;
                else if (WR_DATA[7:0] == 8'd0) m_bcnt = 0;
                else begin
                    m_bw   = m_cyc;
                    m_bcnt = longint'(WR_DATA[7:0]);
                    m_bon  = (WR_DATA[19:8] == 0) ? 1 : longint'(WR_DATA[19:8]);
                    m_boff = (WR_DATA[31:20] == 0) ? 1 : longint'(WR_DATA[31:20]);
                end
            end
        end
        busy = 0;
        on   = 0;
        if (m_bcnt != 0) begin
            j   = m_cyc - m_bw;
            per = (m_bon + m_boff) * TD;
            if (j < m_bcnt * per) begin
                busy = 1;
                on   = (j % per) < m_bon * TD;
            end
        end
        e_led  = m_reg[0];
        e_bz   = busy ? (on ? m_reg[1] : 32'd0) : (m_reg[5][4] ? m_reg[1] : 32'd0);
        e_r    = (m_reg[5][0] && m_reg[5][1]) ? 32'(m_ramp) : m_reg[2];
        e_g    = (m_reg[5][0] && m_reg[5][2]) ? 32'(m_ramp) : m_reg[3];
        e_b    = (m_reg[5][0] && m_reg[5][3]) ? 32'(m_ramp) : m_reg[4];
        e_busy = busy;
        m_cyc++;
        m_valid = 1;
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        WR_EN   = 1'b1;
        WR_ADDR = a;
        WR_DATA = d;
        @(posedge CLK); #1;
        WR_EN   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    function automatic logic [31:0] beep(input int cnt, input int on_t, input int off_t);
        return (32'(off_t) << 20) | (32'(on_t) << 8) | 32'(cnt);
    endfunction

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : p_main
        logic [31:0] rq[$];
        logic [31:0] exp_r[7];
        int          seg_err[4];
        int          s;
        logic [31:0] ev;

        idle(3);
        RST = 1'b0;
        check("rst_led", LED_FREQ_Set, 0);
        check("rst_bz", BZ_FREQ_Set, 0);
        check("rst_busy", BUSY, 0);

        wr(3'd0, 32'd1000); check("wr_led", LED_FREQ_Set, 1000);
        wr(3'd2, 32'd250);  check("wr_r", LEDR_Puty_Set, 250);
        wr(3'd3, 32'd500);  check("wr_g", LEDG_Puty_Set, 500);
        wr(3'd4, 32'd750);  check("wr_b", LEDB_Puty_Set, 750);

        // Breathing on R only
        wr(3'd0, 32'd10);
        wr(3'd6, 32'd4);
        wr(3'd5, 32'h3);
        rq.push_back(LEDR_Puty_Set);
        for (int i = 0; i < 34; i++) begin
            idle(1);
            if (LEDR_Puty_Set != rq[$]) rq.push_back(LEDR_Puty_Set);
        end
        if (rq.size() > 0 && rq[0] == 32'd0) void'(rq.pop_front());
        exp_r = '{32'd4, 32'd8, 32'd10, 32'd6, 32'd2, 32'd0, 32'd4};
        check("breath_len_ok", (rq.size() >= 7) ? 1 : 0, 1);
        for (int i = 0; i < 7; i++)
            check($sformatf("breath_r%0d", i), (i < rq.size()) ? rq[i] : 32'hDEAD, exp_r[i]);
        check("breath_g_static", LEDG_Puty_Set, 500);
        check("breath_b_static", LEDB_Puty_Set, 750);
        wr(3'd5, 32'h0);
        check("breath_off_r", LEDR_Puty_Set, 250);

        // Beep count=2 on=3 off=2
        wr(3'd1, 32'd100);
        check("bz_idle_silent", BZ_FREQ_Set, 0);
        wr(3'd7, beep(2, 3, 2));
        seg_err = '{0, 0, 0, 0};
        for (int i = 0; i < 44; i++) begin
            s  = (i < 12) ? 0 : (i < 20) ? 1 : (i < 32) ? 2 : 3;
            ev = (s == 0 || s == 2) ? 32'd100 : 32'd0;
            if (BZ_FREQ_Set !== ev) seg_err[s]++;
            if (i == 39) check("beep_busy_last_off", BUSY, 1);
            if (i == 40) check("beep_busy_fall", BUSY, 0);
            idle(1);
        end
        for (int k = 0; k < 4; k++) check($sformatf("beep_seg%0d_errs", k), seg_err[k], 0);
        wr(3'd5, 32'h10);
        check("bz_static_idle", BZ_FREQ_Set, 100);

        // Abort during ON, then restart during OFF
        wr(3'd7, beep(1, 5, 5));
        idle(3);
        check("abort_pre_busy", BUSY, 1);
        wr(3'd7, 32'd0);
        check("abort_busy", BUSY, 0);
        check("abort_bz", BZ_FREQ_Set, 100);
        wr(3'd5, 32'h0);
        wr(3'd7, beep(3, 1, 2));
        idle(5);
        check("restart_in_off_bz", BZ_FREQ_Set, 0);
        wr(3'd7, beep(1, 1, 1));
        check("restart_bz", BZ_FREQ_Set, 100);
        check("restart_busy", BUSY, 1);
        idle(8);
        check("restart_done_busy", BUSY, 0);

        // Clamp of a ramp above a newly written LED_FREQ
        wr(3'd6, 32'd3);
        wr(3'd0, 32'd10);
        wr(3'd5, 32'h3);
        for (int k = 0; k < 40 && LEDR_Puty_Set != 32'd9; k++) idle(1);
        check("clamp_reach9", LEDR_Puty_Set, 9);
        wr(3'd0, 32'd5);
        for (int k = 0; k < 10 && LEDR_Puty_Set == 32'd9; k++) idle(1);
        check("clamp_to_freq", LEDR_Puty_Set, 5);
        for (int k = 0; k < 10 && LEDR_Puty_Set == 32'd5; k++) idle(1);
        check("clamp_then_down", LEDR_Puty_Set, 2);

        // Maximum STEP saturates at LED_FREQ
        wr(3'd5, 32'h0);
        wr(3'd0, 32'd7);
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd5, 32'h3);
        for (int k = 0; k < 10 && LEDR_Puty_Set == 32'd0; k++) idle(1);
        check("bigstep_up", LEDR_Puty_Set, 7);
        for (int k = 0; k < 10 && LEDR_Puty_Set == 32'd7; k++) idle(1);
        check("bigstep_down", LEDR_Puty_Set, 0);

        // Reset in the middle of a beep
        wr(3'd5, 32'h13);
        wr(3'd1, 32'd100);
        wr(3'd7, beep(3, 2, 2));
        idle(3);
        check("midbeep_busy", BUSY, 1);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        check("mrst_led", LED_FREQ_Set, 0);
        check("mrst_bz", BZ_FREQ_Set, 0);
        check("mrst_r", LEDR_Puty_Set, 0);
        check("mrst_g", LEDG_Puty_Set, 0);
        check("mrst_b", LEDB_Puty_Set, 0);
        check("mrst_busy", BUSY, 0);
        idle(20);
        check("mrst_quiet_bz", BZ_FREQ_Set, 0);
        check("mrst_quiet_busy", BUSY, 0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
